// File: rtl/pad_reader.sv
// rtl/pad_reader.sv - Genesis 3/6-button pad poller with TH sequencing and decode
module pad_reader #(
  parameter int SETTLE = 8,
  parameter int GAP    = 2000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       ENABLE,
  input  logic [5:0] PIN_IN,
  output logic       TH_OUT,
  output logic       P_UP,
  output logic       P_DOWN,
  output logic       P_LEFT,
  output logic       P_RIGHT,
  output logic       P_A,
  output logic       P_B,
  output logic       P_C,
  output logic       P_START,
  output logic       P_MODE,
  output logic       P_X,
  output logic       P_Y,
  output logic       P_Z,
  output logic       PRESENT,
  output logic       SIX_BTN,
  output logic       FRAME_DONE
);

  // A zero settle time still needs one tick so the pins can follow TH;
  // a zero gap is clamped the same way so the counter width stays legal.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int GAP_EFF    = (GAP < 1) ? 1 : GAP;
  localparam int SW         = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF + 1);
  localparam int GW         = (GAP_EFF < 2) ? 1 : $clog2(GAP_EFF + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_EFF - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_EFF - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [GW-1:0] GAP_ONE     = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE_WAIT,
    S_SAMPLE,
    S_COMMIT,
    S_GAP_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          th_q, th_d;
  logic          gap_owed_q, gap_owed_d;
  logic          sample_en;
  logic          commit_en;

  logic [5:0]    sync1_q, sync2_q;
  logic [5:0]    h1_q, l1_q;
  logic [3:0]    l3_q, h4_q;

  logic          present_dec;
  logic          six_dec;

  // Two-flop synchronizer for the asynchronous pad pins; runs every CLK.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 6'b111111;
      sync2_q <= 6'b111111;
    end else begin
      sync1_q <= PIN_IN;
      sync2_q <= sync1_q;
    end
  end

  // State, phase, timing counters and TH register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      phase_q      <= 3'd0;
      settle_cnt_q <= '0;
      gap_cnt_q    <= '0;
      th_q         <= 1'b1;
      gap_owed_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      settle_cnt_q <= settle_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      th_q         <= th_d;
      gap_owed_q   <= gap_owed_d;
    end
  end

  // Next-state logic. Only CE ticks move the timed states; SAMPLE and COMMIT
  // each take one CLK so the frame length stays at 8*(SETTLE+1)+GAP ticks.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    settle_cnt_d = settle_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    th_d         = th_q;
    gap_owed_d   = gap_owed_q;
    sample_en    = 1'b0;
    commit_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        th_d = 1'b1;
        if (CE) begin
          // After reset the pad's internal counter must time out first.
          if (gap_owed_q) begin
            state_d   = S_GAP_WAIT;
            gap_cnt_d = '0;
          end else if (ENABLE) begin
            state_d = S_DRIVE;
            phase_d = 3'd0;
          end
        end
      end

      S_DRIVE: begin
        if (CE) begin
          if (!ENABLE) begin
            state_d   = S_GAP_WAIT;
            th_d      = 1'b1;
            gap_cnt_d = '0;
          end else begin
            th_d         = ~phase_q[0];
            settle_cnt_d = '0;
            state_d      = S_SETTLE_WAIT;
          end
        end
      end

      S_SETTLE_WAIT: begin
        if (CE) begin
          if (!ENABLE) begin
            state_d   = S_GAP_WAIT;
            th_d      = 1'b1;
            gap_cnt_d = '0;
          end else if (settle_cnt_q >= SETTLE_LAST) begin
            state_d = S_SAMPLE;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_ONE;
          end
        end
      end

      S_SAMPLE: begin
        sample_en = 1'b1;
        if (phase_q == 3'd7) begin
          state_d = S_COMMIT;
        end else begin
          phase_d = phase_q + 3'd1;
          state_d = S_DRIVE;
        end
      end

      S_COMMIT: begin
        commit_en = 1'b1;
        th_d      = 1'b1;
        gap_cnt_d = '0;
        state_d   = S_GAP_WAIT;
      end

      S_GAP_WAIT: begin
        th_d = 1'b1;
        if (CE) begin
          if (gap_cnt_q >= GAP_LAST) begin
            gap_cnt_d  = '0;
            gap_owed_d = 1'b0;
            if (ENABLE) begin
              state_d = S_DRIVE;
              phase_d = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        th_d    = 1'b1;
      end
    endcase
  end

  // Keep only the four phases that carry information; the rest are dropped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h1_q <= 6'b111111;
      l1_q <= 6'b111111;
      l3_q <= 4'b1111;
      h4_q <= 4'b1111;
    end else if (sample_en) begin
      case (phase_q)
        3'd0:    h1_q <= sync2_q;
        3'd1:    l1_q <= sync2_q;
        3'd5:    l3_q <= sync2_q[3:0];
        3'd6:    h4_q <= sync2_q[3:0];
        default: ;
      endcase
    end
  end

  // A Genesis pad pulls LEFT/RIGHT low while TH is low; the 6-button ID
  // additionally pulls all four direction lines low on the third TH-low.
  assign present_dec = (l1_q[3:2] == 2'b00);
  assign six_dec     = present_dec && (l3_q == 4'b0000);

  // All decoded outputs change together in the COMMIT cycle only.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      P_UP       <= 1'b0;
      P_DOWN     <= 1'b0;
      P_LEFT     <= 1'b0;
      P_RIGHT    <= 1'b0;
      P_A        <= 1'b0;
      P_B        <= 1'b0;
      P_C        <= 1'b0;
      P_START    <= 1'b0;
      P_MODE     <= 1'b0;
      P_X        <= 1'b0;
      P_Y        <= 1'b0;
      P_Z        <= 1'b0;
      PRESENT    <= 1'b0;
      SIX_BTN    <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= commit_en;
      if (commit_en) begin
        PRESENT <= present_dec;
        SIX_BTN <= six_dec;
        P_UP    <= present_dec & ~h1_q[0];
        P_DOWN  <= present_dec & ~h1_q[1];
        P_LEFT  <= present_dec & ~h1_q[2];
        P_RIGHT <= present_dec & ~h1_q[3];
        P_B     <= present_dec & ~h1_q[4];
        P_C     <= present_dec & ~h1_q[5];
        P_A     <= present_dec & ~l1_q[4];
        P_START <= present_dec & ~l1_q[5];
        P_Z     <= six_dec & ~h4_q[0];
        P_Y     <= six_dec & ~h4_q[1];
        P_X     <= six_dec & ~h4_q[2];
        P_MODE  <= six_dec & ~h4_q[3];
      end
    end
  end

  assign TH_OUT = th_q;

endmodule

// File: tb/tb_pad_reader.sv
// tb/tb_pad_reader.sv - scoreboard bench for pad_reader with a Genesis pad model
module tb_pad_reader;

  localparam int SETTLE = 4;
  localparam int GAP    = 200;

  // Expected-vector bit positions, also used for the pad's pressed-button set.
  localparam int B_PRES  = 13;
  localparam int B_SIX   = 12;
  localparam int B_UP    = 11;
  localparam int B_DOWN  = 10;
  localparam int B_LEFT  = 9;
  localparam int B_RIGHT = 8;
  localparam int B_A     = 7;
  localparam int B_B     = 6;
  localparam int B_C     = 5;
  localparam int B_START = 4;
  localparam int B_MODE  = 3;
  localparam int B_X     = 2;
  localparam int B_Y     = 1;
  localparam int B_Z     = 0;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CE;
  logic       ENABLE;
  logic [5:0] PIN_IN;
  logic       TH_OUT;
  logic       P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C, P_START;
  logic       P_MODE, P_X, P_Y, P_Z;
  logic       PRESENT, SIX_BTN, FRAME_DONE;

  logic        ce_hold;
  logic [13:0] obs;
  logic [13:0] mon_exp;
  logic [13:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;

  int          pad_kind;
  logic [11:0] pad_btn;
  int          falls = 0;
  int          hi_cnt = 0;
  logic        th_prev = 1'b1;

  pad_reader #(.SETTLE(SETTLE), .GAP(GAP)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .ENABLE(ENABLE), .PIN_IN(PIN_IN),
    .TH_OUT(TH_OUT),
    .P_UP(P_UP), .P_DOWN(P_DOWN), .P_LEFT(P_LEFT), .P_RIGHT(P_RIGHT),
    .P_A(P_A), .P_B(P_B), .P_C(P_C), .P_START(P_START),
    .P_MODE(P_MODE), .P_X(P_X), .P_Y(P_Y), .P_Z(P_Z),
    .PRESENT(PRESENT), .SIX_BTN(SIX_BTN), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  assign CE  = ~ce_hold;
  assign obs = {PRESENT, SIX_BTN, P_UP, P_DOWN, P_LEFT, P_RIGHT, P_A, P_B, P_C,
                P_START, P_MODE, P_X, P_Y, P_Z};

  // Pad model: kind 0 = unplugged, 3 = 3-button, 6 = 6-button.
  // f = TH falling edges since the pad's counter last timed out.
  function automatic logic [5:0] pad_pins(input logic th, input int f,
                                          input int kind, input logic [11:0] b);
    logic [5:0] p;
    if (kind == 0) begin
      p = 6'b111111;
    end else if (th) begin
      if (kind == 6 && f == 3)
        p = ~{b[B_C], b[B_B], b[B_MODE], b[B_X], b[B_Y], b[B_Z]};
      else
        p = ~{b[B_C], b[B_B], b[B_RIGHT], b[B_LEFT], b[B_DOWN], b[B_UP]};
    end else begin
      if (kind == 6 && f == 3)
        p = {~b[B_START], ~b[B_A], 4'b0000};
      else if (kind == 6 && f == 4)
        p = {~b[B_START], ~b[B_A], 4'b1111};
      else
        p = {~b[B_START], ~b[B_A], 2'b00, ~b[B_DOWN], ~b[B_UP]};
    end
    return p;
  endfunction

  always @(posedge CLK) begin
    th_prev <= TH_OUT;
    hi_cnt  <= TH_OUT ? hi_cnt + 1 : 0;
    if (th_prev && !TH_OUT) falls <= falls + 1;
    else if (hi_cnt > 50)   falls <= 0;
  end

  always @* PIN_IN = pad_pins(TH_OUT, falls, pad_kind, pad_btn);

  // Monitor: every FRAME_DONE pulse consumes one expected vector.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && FRAME_DONE === 1'b1) begin
      n_done++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL frame_done_unexpected: got outputs %h at frame %0d, required no FRAME_DONE", obs, n_done);
      end else begin
        mon_exp = exp_q.pop_front();
        if (obs !== mon_exp) begin
          n_err++;
          $display("FAIL frame_outputs #%0d: got %h, required %h", n_done, obs, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, got, got, want, want);
    end
  endtask

  task automatic check_ge(input string name, input int got, input int min);
    n_vec++;
    if (got < min) begin
      n_err++;
      $display("FAIL %s: got %0d, required at least %0d", name, got, min);
    end
  endtask

  task automatic wait_done(input int start, input string name);
    int k;
    k = 0;
    while (n_done == start && k < 2000) begin
      @(posedge CLK);
      k++;
    end
    if (n_done == start) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no FRAME_DONE in 2000 clocks, required one", name);
    end
  endtask

  task automatic run_frame(input int kind, input logic [11:0] btn,
                           input logic [13:0] e, input string name);
    int start;
    start    = n_done;
    pad_kind = kind;
    pad_btn  = btn;
    exp_q.push_back(e);
    wait_done(start, name);
  endtask

  // Wait at negedges for the pad to be in the TH-low phase after n falls.
  task automatic wait_low_phase(input int n, input string name);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!(falls == n && TH_OUT == 1'b0) && k < 2000);
    if (!(falls == n && TH_OUT == 1'b0)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no TH-low phase after %0d falls, required one", name, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int cnt;
    int th_moved;
    int start_dummy;

    RESET_N  = 1'b0;
    ENABLE   = 1'b0;
    ce_hold  = 1'b0;
    pad_kind = 0;
    pad_btn  = 12'h000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_th_out", 32'(TH_OUT), 32'd1);
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_frame_done", 32'(FRAME_DONE), 32'd0);

    // No pad: decoded all-zero, but FRAME_DONE still pulses.
    ENABLE  = 1'b1;
    RESET_N = 1'b1;
    run_frame(0, 12'h000, 14'h0000, "no_pad");

    // 3-button A+RIGHT.
    run_frame(3, 12'h000 | (12'd1 << B_A) | (12'd1 << B_RIGHT), 14'h2180, "3btn_a_right");
    // 3-button UP+B+C+START with X held: X must not appear.
    run_frame(3, (12'd1 << B_UP) | (12'd1 << B_B) | (12'd1 << B_C) | (12'd1 << B_START) | (12'd1 << B_X),
              14'h2870, "3btn_up_b_c_start");
    // 6-button X+START.
    run_frame(6, (12'd1 << B_X) | (12'd1 << B_START), 14'h3014, "6btn_x_start");
    // 6-button MODE+Z+LEFT+DOWN+A.
    run_frame(6, (12'd1 << B_MODE) | (12'd1 << B_Z) | (12'd1 << B_LEFT) | (12'd1 << B_DOWN) | (12'd1 << B_A),
              14'h3689, "6btn_mode_z_left_down_a");

    // ENABLE dropped in phase 3: no commit, TH held high through the gap.
    pad_kind = 6;
    pad_btn  = (12'd1 << B_Y) | (12'd1 << B_C) | (12'd1 << B_RIGHT);
    wait_low_phase(2, "abort_reach_phase3");
    ENABLE = 1'b0;
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (!TH_OUT && cnt < 20);
    check("abort_th_high", 32'(TH_OUT), 32'd1);
    check("abort_outputs_kept", 32'(obs), 32'h3689);
    repeat (50) @(negedge CLK);
    start = n_done;
    exp_q.push_back(14'h3122);
    ENABLE = 1'b1;
    cnt = 50;
    while (TH_OUT && cnt < 5000) begin
      @(negedge CLK);
      cnt++;
    end
    check_ge("abort_th_high_len", cnt, GAP);
    wait_done(start, "after_abort_frame");

    // CE held low for 100 CLK inside the phase-1 settle window.
    start    = n_done;
    pad_kind = 3;
    pad_btn  = (12'd1 << B_DOWN) | (12'd1 << B_START);
    exp_q.push_back(14'h2410);
    cnt = 0;
    while (TH_OUT && cnt < 2000) begin
      @(negedge CLK);
      cnt++;
    end
    cnt = 0;
    th_moved = 0;
    do begin
      @(negedge CLK);
      cnt++;
      if (cnt == 1) ce_hold = 1'b1;
      else if (cnt == 101) ce_hold = 1'b0;
      if (cnt <= 101 && TH_OUT) th_moved++;
    end while (!TH_OUT && cnt < 1000);
    check("ce_hold_th_frozen", 32'(th_moved), 32'd0);
    check("ce_hold_low_phase_len", 32'(cnt), 32'd106);
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (TH_OUT && cnt < 1000);
    check("normal_phase_len", 32'(cnt), 32'd6);
    wait_done(start, "ce_hold_frame");

    // Reset pulsed in phase 5 with nonzero outputs.
    pad_kind = 3;
    pad_btn  = (12'd1 << B_A) | (12'd1 << B_RIGHT);
    wait_low_phase(3, "reset_reach_phase5");
    RESET_N = 1'b0;
    #1;
    check("reset_mid_outputs", 32'(obs), 32'd0);
    check("reset_mid_th_out", 32'(TH_OUT), 32'd1);
    check("reset_mid_frame_done", 32'(FRAME_DONE), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    start = n_done;
    exp_q.push_back(14'h2180);
    RESET_N = 1'b1;
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (TH_OUT && cnt < 5000);
    check_ge("reset_first_th_fall", cnt, GAP + 8);
    wait_done(start, "after_reset_frame");

    ENABLE = 1'b0;
    start_dummy = GAP + 20;
    repeat (start_dummy) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
